// File: rtl/game_overlord.sv
// game_overlord: round-control FSM for the torpedo game.
// Issues sprite reload pulses, launches the torpedo on a fire-key edge,
// scores target/torpedo overlap per frame and hands the round result to
// the end-of-game timer and mixer. All outputs are registered.
module game_overlord #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned X_WIDTH       = 10,
    parameter int unsigned Y_WIDTH       = 10,
    parameter int unsigned MIN_OVERLAP   = 4,
    parameter int unsigned OVL_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key,
    input  logic               display_on,
    input  logic [X_WIDTH-1:0] pixel_x,
    input  logic [Y_WIDTH-1:0] pixel_y,
    input  logic               sprite_target_rgb_en,
    input  logic               sprite_torpedo_rgb_en,
    input  logic               sprite_target_out_of_screen,
    input  logic               sprite_torpedo_out_of_screen,
    input  logic               end_of_game_timer_running,
    output logic               sprite_target_write,
    output logic               sprite_torpedo_write,
    output logic               torpedo_launch,
    output logic               end_of_game_timer_start,
    output logic               game_won
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_AIM   = 2'd1;
    localparam logic [1:0] ST_SHOOT = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

    logic [1:0]           state;
    logic                 key_meta;
    logic                 key_sync;
    logic                 key_prev;
    logic                 key_edge;
    logic                 frame_end;
    logic                 overlap_px;
    logic [OVL_WIDTH-1:0] ovl_cnt;
    logic [OVL_WIDTH-1:0] ovl_next;
    logic                 hit;
    logic                 timer_seen;

    // Two-flop synchroniser for the asynchronous fire key plus edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_meta <= 1'b0;
            key_sync <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
            key_prev <= key_sync;
        end
    end

    assign key_edge   = key_sync & ~key_prev;
    assign frame_end  = display_on
                      && (pixel_x == X_WIDTH'(SCREEN_WIDTH - 1))
                      && (pixel_y == Y_WIDTH'(SCREEN_HEIGHT - 1));
    assign overlap_px = display_on & sprite_target_rgb_en & sprite_torpedo_rgb_en;

    // Saturating next count; includes the current pixel so the frame_end pixel scores.
    always_comb begin
        ovl_next = ovl_cnt;
        if (overlap_px && (ovl_cnt != '1)) begin
            ovl_next = ovl_cnt + OVL_WIDTH'(1);
        end
        hit = (ovl_next >= OVL_WIDTH'(MIN_OVERLAP));
    end

    // Overlap counter: accumulates only while the torpedo is in flight, restarts each frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovl_cnt <= '0;
        end else if ((state != ST_SHOOT) || frame_end) begin
            ovl_cnt <= '0;
        end else begin
            ovl_cnt <= ovl_next;
        end
    end

    // Round FSM with registered outputs; write/start strobes default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= ST_START;
            sprite_target_write     <= 1'b0;
            sprite_torpedo_write    <= 1'b0;
            torpedo_launch          <= 1'b0;
            end_of_game_timer_start <= 1'b0;
            game_won                <= 1'b0;
            timer_seen              <= 1'b0;
        end else begin
            sprite_target_write     <= 1'b0;
            sprite_torpedo_write    <= 1'b0;
            end_of_game_timer_start <= 1'b0;
            case (state)
                ST_START: begin
                    sprite_target_write  <= 1'b1;
                    sprite_torpedo_write <= 1'b1;
                    torpedo_launch       <= 1'b0;
                    game_won             <= 1'b0;
                    timer_seen           <= 1'b0;
                    state                <= ST_AIM;
                end
                ST_AIM: begin
                    if (sprite_target_out_of_screen) begin
                        state <= ST_START;
                    end else if (key_edge) begin
                        sprite_torpedo_write <= 1'b1;
                        torpedo_launch       <= 1'b1;
                        state                <= ST_SHOOT;
                    end
                end
                ST_SHOOT: begin
                    if (frame_end) begin
                        if (hit) begin
                            game_won                <= 1'b1;
                            end_of_game_timer_start <= 1'b1;
                            torpedo_launch          <= 1'b0;
                            state                   <= ST_END;
                        end else if (sprite_torpedo_out_of_screen || sprite_target_out_of_screen) begin
                            game_won                <= 1'b0;
                            end_of_game_timer_start <= 1'b1;
                            torpedo_launch          <= 1'b0;
                            state                   <= ST_END;
                        end
                    end
                end
                ST_END: begin
                    if (end_of_game_timer_running) begin
                        timer_seen <= 1'b1;
                    end
                    if (timer_seen && !end_of_game_timer_running) begin
                        state <= ST_START;
                    end
                end
                default: state <= ST_START;
            endcase
        end
    end

endmodule

// File: tb/tb_game_overlord.sv
// tb_game_overlord: directed scoreboard bench for game_overlord with a small
// raster generator (16x8 visible, 20x10 total) and a 10-cycle timer model.
module tb_game_overlord;

    localparam logic [9:0] SW      = 10'd16;
    localparam logic [9:0] SH      = 10'd8;
    localparam logic [9:0] H_TOTAL = 10'd20;
    localparam logic [9:0] V_TOTAL = 10'd10;

    // {target_write, torpedo_write, launch, timer_start, game_won}
    localparam logic [4:0] EV_START  = 5'b11000;
    localparam logic [4:0] EV_LAUNCH = 5'b01100;
    localparam logic [4:0] EV_WIN    = 5'b00011;
    localparam logic [4:0] EV_LOSS   = 5'b00010;

    logic       clk = 1'b0;
    logic       reset;
    logic       key;
    logic       tgt_oos;
    logic       tor_oos;
    logic [9:0] ovl_n;
    logic [9:0] hx;
    logic [9:0] vy;
    logic       display_on;
    logic       tgt_en;
    logic       tor_en;
    logic [3:0] timer_cnt;
    logic       timer_running;

    logic       tw;
    logic       torw;
    logic       launch;
    logic       ts;
    logic       won;
    logic [4:0] obs;
    logic [2:0] pulses;
    logic [2:0] prev_pulse;
    logic [4:0] ev;

    logic [4:0]  exp_q[$];
    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    game_overlord #(
        .SCREEN_WIDTH (16),
        .SCREEN_HEIGHT(8),
        .X_WIDTH      (10),
        .Y_WIDTH      (10),
        .MIN_OVERLAP  (4),
        .OVL_WIDTH    (8)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .key                         (key),
        .display_on                  (display_on),
        .pixel_x                     (hx),
        .pixel_y                     (vy),
        .sprite_target_rgb_en        (tgt_en),
        .sprite_torpedo_rgb_en       (tor_en),
        .sprite_target_out_of_screen (tgt_oos),
        .sprite_torpedo_out_of_screen(tor_oos),
        .end_of_game_timer_running   (timer_running),
        .sprite_target_write         (tw),
        .sprite_torpedo_write        (torw),
        .torpedo_launch              (launch),
        .end_of_game_timer_start     (ts),
        .game_won                    (won)
    );

    assign obs    = {tw, torw, launch, ts, won};
    assign pulses = {tw, torw, ts};

    // Raster generator
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hx <= '0;
            vy <= '0;
        end else if (hx == H_TOTAL - 10'd1) begin
            hx <= '0;
            vy <= (vy == V_TOTAL - 10'd1) ? 10'd0 : vy + 10'd1;
        end else begin
            hx <= hx + 10'd1;
        end
    end

    assign display_on = (hx < SW) && (vy < SH);
    // Target is two pixels wider than torpedo on row 2: overlap is exactly ovl_n pixels.
    assign tgt_en = display_on && (vy == 10'd2) && (hx < ovl_n + 10'd2);
    assign tor_en = display_on && (vy == 10'd2) && (hx < ovl_n);

    // End-of-game timer model: busy for 10 cycles after a start pulse.
    always @(posedge clk or negedge reset) begin
        if (!reset)              timer_cnt <= '0;
        else if (ts)             timer_cnt <= 4'd10;
        else if (timer_cnt != 0) timer_cnt <= timer_cnt - 4'd1;
    end
    assign timer_running = (timer_cnt != 4'd0);

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: every strobe is matched against the next expected event.
    always @(negedge clk) begin
        if (reset && (pulses != 3'b000)) begin
            check("pulse_width", 32'(pulses & prev_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(obs), 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check("pulse_event", 32'(obs), 32'(ev));
            end
        end
        prev_pulse <= reset ? pulses : 3'b000;
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Wait until the raster has just entered vertical blanking; next frame is untouched.
    task automatic align_vblank();
        int unsigned n = 0;
        cyc(1);
        while (!((hx == 10'd0) && (vy == SH)) && (n < 300)) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic fire(input string tag);
        exp_q.push_back(EV_LAUNCH);
        key = 1'b1;
        drain(tag, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        key     = 1'b0;
        tgt_oos = 1'b0;
        tor_oos = 1'b0;
        ovl_n   = '0;
        cyc(3);
        check("reset_outputs", 32'(obs), 32'd0);

        // Reset release: single START strobe pair, then idle AIM for 3 frames
        exp_q.push_back(EV_START);
        reset = 1'b1;
        drain("start_after_reset", 5);
        cyc(600);
        check("aim_idle_launch", 32'(launch), 32'd0);

        // Key edge in AIM launches
        fire("launch_1");
        key = 1'b0;
        check("shoot_launch_level", 32'(launch), 32'd1);

        // 5 overlaps -> win, timer handshake, restart
        align_vblank();
        ovl_n = 10'd5;
        exp_q.push_back(EV_WIN);
        drain("hit5_win", 300);
        check("end_won_held", 32'({launch, won}), 32'b01);
        ovl_n = '0;
        exp_q.push_back(EV_START);
        drain("restart_after_win", 40);
        check("won_cleared_start", 32'(won), 32'd0);

        // Target leaves screen while aiming -> respawn
        exp_q.push_back(EV_START);
        tgt_oos = 1'b1;
        cyc(1);
        tgt_oos = 1'b0;
        drain("aim_respawn", 5);

        // 3 overlaps per frame never accumulate; then 3 + torpedo off-screen -> loss
        fire("launch_2");
        key = 1'b0;
        align_vblank();
        ovl_n = 10'd3;
        cyc(400);
        check("no_hit_3x2_launch", 32'(launch), 32'd1);
        tor_oos = 1'b1;
        exp_q.push_back(EV_LOSS);
        drain("oos_loss", 300);
        tor_oos = 1'b0;
        ovl_n   = '0;
        check("end_lost_held", 32'({launch, won}), 32'b00);
        exp_q.push_back(EV_START);
        drain("restart_after_loss", 40);

        // 4 overlaps + target off-screen in the same frame -> hit has priority
        fire("launch_3");
        key = 1'b0;
        align_vblank();
        ovl_n   = 10'd4;
        tgt_oos = 1'b1;
        exp_q.push_back(EV_WIN);
        drain("hit4_priority", 300);
        tgt_oos = 1'b0;
        ovl_n   = '0;
        check("end_won_priority", 32'(won), 32'd1);
        exp_q.push_back(EV_START);
        drain("restart_after_priority", 40);

        // Key held across the whole round: no relaunch on return to AIM
        fire("launch_4");
        align_vblank();
        ovl_n = 10'd5;
        exp_q.push_back(EV_WIN);
        exp_q.push_back(EV_START);
        drain("held_key_round", 400);
        ovl_n = '0;
        cyc(400);
        check("held_key_no_relaunch", 32'(launch), 32'd0);

        // Reset mid-round in SHOOT
        key = 1'b0;
        cyc(5);
        fire("launch_5");
        cyc(20);
        reset = 1'b0;
        cyc(2);
        check("reset_midround", 32'(obs), 32'd0);
        key = 1'b0;
        cyc(2);
        exp_q.push_back(EV_START);
        reset = 1'b1;
        drain("start_after_midreset", 5);
        cyc(200);
        check("post_reset_idle", 32'({launch, won}), 32'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
